// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with blanking guard and frame-aligned value commit.
// Optional macro LEADING_ZERO_BLANK_EN suppresses leading zero digits (digit 0 is never suppressed).
module seg_scan_ctrl #(
    parameter int unsigned DIGIT_PERIOD = 100000,
    parameter int unsigned BLANK_CYCLES = 2000
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic [31:0] value,
    input  logic [7:0]  dp_in,
    input  logic [7:0]  digit_en,
    input  logic        load,
    output logic        load_ack,
    output logic        frame_done,
    output logic [7:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP
);

    localparam int unsigned CTR_W = (DIGIT_PERIOD > 1) ? $clog2(DIGIT_PERIOD) : 1;
    localparam logic [CTR_W-1:0] CTR_LAST  = CTR_W'(DIGIT_PERIOD - 1);
    localparam logic [CTR_W-1:0] BLANK_CTR = CTR_W'(BLANK_CYCLES);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_DRIVE = 1'b1;

    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [2:0]       idx_q, idx_d;
    logic [0:0]       state_q, state_d;

    logic [31:0] shadow_value_q, shadow_value_d;
    logic [7:0]  shadow_dp_q, shadow_dp_d;
    logic [7:0]  shadow_en_q, shadow_en_d;

    logic [31:0] pend_value_q, pend_value_d;
    logic [7:0]  pend_dp_q, pend_dp_d;
    logic [7:0]  pend_en_q, pend_en_d;
    logic        pending_q, pending_d;

    logic        slot_end;
    logic        wrap;

    logic [7:0]  an_d;
    logic [6:0]  seg_d;
    logic        dp_d;
    logic [3:0]  nibble;
    logic        upper_zero;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign slot_end = (ctr_q == CTR_LAST);
    assign wrap     = slot_end && (idx_q == 3'd7);

    // Slot counter, digit index and blank/drive phase
    always_comb begin
        ctr_d   = slot_end ? '0 : ctr_q + 1'b1;
        idx_d   = slot_end ? idx_q + 3'd1 : idx_q;
        state_d = state_q;
        if (ctr_d == '0) begin
            state_d = (BLANK_CYCLES == 0) ? ST_DRIVE : ST_BLANK;
        end else if (ctr_d == BLANK_CTR) begin
            state_d = ST_DRIVE;
        end
    end

    // Pending/shadow handshake; a commit on the wrap always uses the pre-cycle pending contents
    always_comb begin
        pend_value_d   = pend_value_q;
        pend_dp_d      = pend_dp_q;
        pend_en_d      = pend_en_q;
        pending_d      = pending_q;
        shadow_value_d = shadow_value_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_en_d    = shadow_en_q;

        if (wrap && pending_q) begin
            shadow_value_d = pend_value_q;
            shadow_dp_d    = pend_dp_q;
            shadow_en_d    = pend_en_q;
            pending_d      = 1'b0;
        end
        if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp_in;
            pend_en_d    = digit_en;
            pending_d    = 1'b1;
        end
    end

    assign nibble     = shadow_value_q[{idx_q, 2'b00} +: 4];
    assign upper_zero = ((shadow_value_q >> {idx_q, 2'b00}) == 32'd0);

    always_comb begin
        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_q == ST_DRIVE) begin
            an_d[idx_q] = 1'b0;
            if (shadow_en_q[idx_q]) begin
                seg_d = hex_to_seg(nibble);
                dp_d  = ~shadow_dp_q[idx_q];
`ifdef LEADING_ZERO_BLANK_EN
                if ((idx_q != 3'd0) && upper_zero) begin
                    seg_d = 7'h7F;
                end
`else
                if (1'b0 && upper_zero) begin
                    seg_d = 7'h7F;
                end
`endif
            end
        end
    end

    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            ctr_q          <= '0;
            idx_q          <= 3'd0;
            state_q        <= ST_BLANK;
            shadow_value_q <= 32'd0;
            shadow_dp_q    <= 8'd0;
            shadow_en_q    <= 8'd0;
            pend_value_q   <= 32'd0;
            pend_dp_q      <= 8'd0;
            pend_en_q      <= 8'd0;
            pending_q      <= 1'b0;
            AN             <= 8'hFF;
            SEG            <= 7'h7F;
            DP             <= 1'b1;
            load_ack       <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            ctr_q          <= ctr_d;
            idx_q          <= idx_d;
            state_q        <= state_d;
            shadow_value_q <= shadow_value_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_en_q    <= shadow_en_d;
            pend_value_q   <= pend_value_d;
            pend_dp_q      <= pend_dp_d;
            pend_en_q      <= pend_en_d;
            pending_q      <= pending_d;
            AN             <= an_d;
            SEG            <= seg_d;
            DP             <= dp_d;
            load_ack       <= wrap && pending_q;
            frame_done     <= wrap;
        end
    end

endmodule
